// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: show-ahead read data, trigger level, DMA request, single-cycle updates; writes while full are dropped and flag overrun.
// Optional character timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 640
) (
  input  logic                   m_clk,
  input  logic                   reset,
  input  logic                   FIFO_EN,
  input  logic                   DMA_MODE,
  input  logic                   fifo_clr,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  input  logic [1:0]             trig_lvl,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overrun,
  output logic                   trig_hit,
  output logic                   dma_req,
  output logic                   timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CAP_FIFO = CW'(DEPTH);
  localparam logic [CW-1:0] THR_1    = CW'(1);
  localparam logic [CW-1:0] THR_Q    = CW'(DEPTH / 4);
  localparam logic [CW-1:0] THR_H    = CW'(DEPTH / 2);
  localparam logic [CW-1:0] THR_NF   = CW'(DEPTH - 2);

  if ((1 << AW) != DEPTH || DEPTH < 4 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("uart_rx_fifo: DEPTH must be a power of two >= 4 and TIMEOUT_CYC >= 1");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, cap, thr;
  logic          overrun_q, overrun_d;
  logic          dma_q, dma_d, dma_set;
  logic          fifo_en_q;
  logic          flush, do_wr, do_rd;

  // A mode change reorganises capacity, so it discards the queue like fifo_clr.
  assign flush = fifo_clr | (FIFO_EN != fifo_en_q);
  assign cap   = FIFO_EN ? CAP_FIFO : CNT_ONE;
  assign empty = (count_q == '0);
  assign full  = (count_q == cap);
  assign do_wr = wr_en & (~full | rd_en) & ~flush;
  assign do_rd = rd_en & ~empty & ~flush;

  assign count   = count_q;
  assign overrun = overrun_q;
  assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    case (trig_lvl)
      2'd0:    thr = THR_1;
      2'd1:    thr = THR_Q;
      2'd2:    thr = THR_H;
      default: thr = THR_NF;
    endcase
  end

  assign trig_hit = FIFO_EN ? (count_q >= thr) : ~empty;
  assign dma_req  = DMA_MODE ? dma_q : ~empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    dma_d     = dma_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
      dma_d     = 1'b0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (wr_en && full && !rd_en) overrun_d = 1'b1;
      if (dma_set)    dma_d = 1'b1;
      else if (empty) dma_d = 1'b0;
    end
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      dma_q     <= 1'b0;
      fifo_en_q <= FIFO_EN;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      dma_q     <= dma_d;
      fifo_en_q <= FIFO_EN;
    end
  end

  always_ff @(posedge m_clk) begin
    if (do_wr && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);
  localparam logic [IW-1:0] IDLE_ONE = IW'(1);

  logic [IW-1:0] idle_q, idle_d;
  logic          to_q, to_d;

  // Idle count saturates so a long-idle queue keeps timeout asserted until serviced.
  always_comb begin
    idle_d = idle_q;
    to_d   = to_q;
    if (flush || empty || wr_en || rd_en) idle_d = '0;
    else if (idle_q != IDLE_MAX)          idle_d = idle_q + IDLE_ONE;
    if (flush || empty || rd_en)          to_d = 1'b0;
    else if (idle_d == IDLE_MAX)          to_d = 1'b1;
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end

  assign timeout = to_q;
  assign dma_set = trig_hit | to_q;
`else
  assign timeout = 1'b0;
  assign dma_set = trig_hit;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model; popped data is compared by a separate monitor.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int TO_CYC = 8;

  logic       m_clk = 1'b0;
  logic       reset, FIFO_EN, DMA_MODE, fifo_clr, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic [1:0] trig_lvl;
  logic [4:0] count;
  logic       empty, full, overrun, trig_hit, dma_req, timeout;

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
    .m_clk    (m_clk),
    .reset    (reset),
    .FIFO_EN  (FIFO_EN),
    .DMA_MODE (DMA_MODE),
    .fifo_clr (fifo_clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .trig_lvl (trig_lvl),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overrun  (overrun),
    .trig_hit (trig_hit),
    .dma_req  (dma_req),
    .timeout  (timeout)
  );

  always #5 m_clk = ~m_clk;

  logic [7:0] exp_q[$];
  bit m_ovr, m_dma, m_to, m_fen_prev, mon_pop, chk_en;
  int m_idle, n_cmp, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int thr_of(input logic [1:0] code);
    case (code)
      2'd0:    return 1;
      2'd1:    return 4;
      2'd2:    return 8;
      default: return 14;
    endcase
  endfunction

  // Monitor: compares visible state, and consumes the head whenever a pop is due.
  always @(negedge m_clk) begin
    int sz, cap;
    if (chk_en) begin
      sz  = exp_q.size();
      cap = FIFO_EN ? DEPTH : 1;
      chk("rd_data",  {24'd0, rd_data}, (sz > 0) ? {24'd0, exp_q[0]} : 32'd0);
      chk("count",    {27'd0, count}, sz);
      chk("empty",    {31'd0, empty}, (sz == 0));
      chk("full",     {31'd0, full}, (sz == cap));
      chk("overrun",  {31'd0, overrun}, m_ovr);
      chk("trig_hit", {31'd0, trig_hit}, FIFO_EN ? (sz >= thr_of(trig_lvl)) : (sz > 0));
      chk("dma_req",  {31'd0, dma_req}, DMA_MODE ? m_dma : (sz > 0));
      chk("timeout",  {31'd0, timeout}, m_to);
      if (mon_pop) void'(exp_q.pop_front());
    end
  end

  task automatic step(input bit w, input logic [7:0] d, input bit r);
    int sz, cap;
    bit flush, acc, ovr_set, trig;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    sz      = exp_q.size();
    cap     = FIFO_EN ? DEPTH : 1;
    flush   = reset || fifo_clr || (FIFO_EN != m_fen_prev);
    acc     = !flush && w && (sz < cap || (r && sz == cap));
    ovr_set = !flush && w && !r && sz == cap;
    trig    = FIFO_EN ? (sz >= thr_of(trig_lvl)) : (sz > 0);
    mon_pop = !flush && r && sz > 0;
    @(posedge m_clk);
    #1;
    mon_pop = 1'b0;
    if (flush) begin
      exp_q.delete();
      m_ovr = 0; m_dma = 0; m_to = 0; m_idle = 0;
    end else begin
      if (acc) exp_q.push_back(d);
      if (ovr_set) m_ovr = 1;
      if (trig || m_to) m_dma = 1;
      else if (sz == 0) m_dma = 0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
      if (sz == 0 || w || r) m_idle = 0;
      else if (m_idle < TO_CYC) m_idle++;
      if (sz == 0 || r) m_to = 0;
      else if (m_idle == TO_CYC) m_to = 1;
`endif
    end
    m_fen_prev = FIFO_EN;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 1; i <= n; i++) step(1, base + 8'(i), 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 1);
  endtask

  initial begin
    int wp;
    reset = 1; FIFO_EN = 1; DMA_MODE = 0; fifo_clr = 0;
    wr_en = 0; rd_en = 0; wr_data = 0; trig_lvl = 0;
    m_fen_prev = 1; chk_en = 0; n_cmp = 0; n_err = 0;
    step(0, 8'h00, 0);
    chk_en = 1;
    step(0, 8'h00, 0);
    reset = 0;
    idle(1);

    // In-order fill to full and drain to empty
    fill(8'h00, 16); idle(1);
    drain(16); idle(1);

    // Overrun: write to a full queue is dropped
    fill(8'h20, 16);
    step(1, 8'hAA, 0); idle(1);
    drain(16); idle(1);
    fifo_clr = 1; step(1, 8'h99, 1); fifo_clr = 0; idle(1);

    // Write+read while full, then read while empty and write+read while empty
    fill(8'h40, 16);
    step(1, 8'h55, 1); idle(1);
    drain(16);
    step(0, 8'h00, 1);
    step(1, 8'h77, 1); idle(1);
    drain(1); idle(1);

    // DMA mode 1 with threshold 8
    DMA_MODE = 1; trig_lvl = 2'b10;
    fill(8'h60, 8); idle(2);
    drain(7); idle(2);
    drain(1); idle(2);
    DMA_MODE = 0; trig_lvl = 2'b00;

    // Holding-register mode
    FIFO_EN = 0; idle(1);
    step(1, 8'h3C, 0);
    step(1, 8'h3D, 0); idle(1);
    drain(1); idle(1);
    FIFO_EN = 1; idle(1);

    // Mode toggle mid-fill flushes
    fill(8'h80, 5);
    FIFO_EN = 0; step(1, 8'h90, 0); idle(1);
    FIFO_EN = 1; step(1, 8'h91, 0); idle(1);
    drain(1);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // Character timeout after TO_CYC idle cycles, cleared by one read
    step(1, 8'hC1, 0); idle(TO_CYC + 2);
    drain(1); idle(1);
    DMA_MODE = 1; trig_lvl = 2'b11;
    fill(8'hD0, 2); idle(TO_CYC + 2);
    drain(2); idle(2);
    DMA_MODE = 0; trig_lvl = 2'b00;
`endif

    // Reset mid-burst discards data
    fill(8'hE0, 6);
    reset = 1; step(1, 8'hEE, 1); reset = 0;
    fill(8'hF0, 3); drain(3); idle(1);

    // Random traffic with varying write pressure
    for (int blk = 0; blk < 20; blk++) begin
      wp = $urandom_range(20, 80);
      trig_lvl = 2'($urandom_range(0, 3));
      DMA_MODE = 1'($urandom_range(0, 1));
      for (int i = 0; i < 150; i++) begin
        fifo_clr = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 299) == 0) FIFO_EN = ~FIFO_EN;
        step($urandom_range(0, 99) < wp, 8'($urandom),
             $urandom_range(0, 99) < (100 - wp));
        fifo_clr = 0;
      end
    end
    FIFO_EN = 1; idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
